// File: rtl/hilo_muldiv.sv
// hilo_muldiv: E-stage HI/LO unit with single-cycle MTHI/MTLO/MULT and a 32-step restoring divider.
// Define MULDIV_ITER_MULT_EN to make MULT/MULTU a 32-step shift-add sharing the divider's datapath.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       alucontrolE,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             done_o
);
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef MULDIV_ITER_MULT_EN
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE, S_MUL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic              negq_q, negq_d, negr_q, negr_d, divz_q, divz_d;

  logic              accept, sgn, iter_op, load;
  logic [WIDTH-1:0]  mag_a, mag_b, quo_res, rem_res, diff;
  logic [WIDTH:0]    shifted;
`ifdef MULDIV_ITER_MULT_EN
  logic              mul_q, mul_d;
  logic [WIDTH:0]    sum;
  logic [2*WIDTH-1:0] prod_mag, prod_res;
`else
  logic [2*WIDTH-1:0] prod_s, prod_u;
`endif

  assign accept = (state_q == S_IDLE) && valid_i && !flush_i;
  assign sgn    = (alucontrolE == EXE_DIV_OP) || (alucontrolE == EXE_MULT_OP);
  assign mag_a  = (sgn && srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign mag_b  = (sgn && srcbE[WIDTH-1]) ? -srcbE : srcbE;
`ifdef MULDIV_ITER_MULT_EN
  assign iter_op = (alucontrolE == EXE_DIV_OP) || (alucontrolE == EXE_DIVU_OP) ||
                   (alucontrolE == EXE_MULT_OP) || (alucontrolE == EXE_MULTU_OP);
  assign sum      = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
  assign prod_mag = {rem_q, quo_q};
  assign prod_res = negq_q ? -prod_mag : prod_mag;
`else
  assign iter_op = (alucontrolE == EXE_DIV_OP) || (alucontrolE == EXE_DIVU_OP);
  assign prod_s  = $signed({{WIDTH{srcaE[WIDTH-1]}}, srcaE}) * $signed({{WIDTH{srcbE[WIDTH-1]}}, srcbE});
  assign prod_u  = {{WIDTH{1'b0}}, srcaE} * {{WIDTH{1'b0}}, srcbE};
`endif
  assign load = accept && iter_op;

  // Restoring step: partial remainder never exceeds the divisor, so WIDTH+1 bits suffice.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted[WIDTH-1:0] - dvs_q;
  assign quo_res = negq_q ? -quo_q : quo_q;
  assign rem_res = negr_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    divz_d  = divz_q;
`ifdef MULDIV_ITER_MULT_EN
    mul_d   = mul_q;
`endif
    stall_o = 1'b0;
    done_o  = 1'b0;

    if (load) begin
      rem_d   = '0;
      quo_d   = mag_a;
      dvs_d   = mag_b;
      dvd_d   = srcaE;
      negq_d  = sgn && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
      negr_d  = sgn && srcaE[WIDTH-1];
      divz_d  = (srcbE == '0);
      cnt_d   = CNT_LAST;
      stall_o = 1'b1;
`ifdef MULDIV_ITER_MULT_EN
      mul_d   = (alucontrolE == EXE_MULT_OP) || (alucontrolE == EXE_MULTU_OP);
      state_d = mul_d ? S_MUL : S_DIV;
`else
      state_d = S_DIV;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (alucontrolE)
            EXE_MTHI_OP:  hi_d = srcaE;
            EXE_MTLO_OP:  lo_d = srcaE;
`ifndef MULDIV_ITER_MULT_EN
            EXE_MULT_OP:  {hi_d, lo_d} = prod_s;
            EXE_MULTU_OP: {hi_d, lo_d} = prod_u;
`endif
            default: ;
          endcase
        end
      end
      S_DIV: begin
        stall_o = 1'b1;
        if (shifted >= {1'b0, dvs_q}) begin
          rem_d = diff;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
`ifdef MULDIV_ITER_MULT_EN
      S_MUL: begin
        stall_o = 1'b1;
        rem_d   = sum[WIDTH:1];
        quo_d   = {sum[0], quo_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
`endif
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
`ifdef MULDIV_ITER_MULT_EN
        if (mul_q) begin
          {hi_d, lo_d} = prod_res;
        end else
`endif
        if (divz_q) begin
          hi_d = dvd_q;
          lo_d = '1;
        end else begin
          hi_d = rem_res;
          lo_d = quo_res;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything: abandon the op, keep HI/LO, release the stall.
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      stall_o = 1'b0;
      done_o  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      divz_q  <= 1'b0;
`ifdef MULDIV_ITER_MULT_EN
      mul_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      divz_q  <= divz_d;
`ifdef MULDIV_ITER_MULT_EN
      mul_q   <= mul_d;
`endif
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule
